// File: rtl/matrix_mem_responder.sv
// Memory-side responder for the accelerator request protocol: word scratchpad
// serving engine reads/writes with fixed latency plus an idle-time host port.
`ifndef TYPE_BW
`define TYPE_BW 32
`endif

module matrix_mem_responder #(
    parameter int unsigned DATA_W = `TYPE_BW,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LAT    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        mem_operation,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_opdone,
    output logic              err_o,
    input  logic              err_clr,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state, state_next;
    logic [3:0]         cnt, cnt_next;
    logic [1:0]         op_q;
    logic [31:0]        addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               accept, complete, host_go;
    logic               in_range, is_rd, is_wr, is_ill;
    logic [ADDR_W-1:0]  idx;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;

    // Full 32-bit range check; only then do the low bits index the RAM.
    assign in_range = (addr_q >> ADDR_W) == 32'd0;
    assign idx      = addr_q[ADDR_W-1:0];
    assign is_rd    = (op_q == 2'b01);
    assign is_wr    = (op_q == 2'b11);
    assign is_ill   = (op_q == 2'b10);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        complete   = 1'b0;
        host_go    = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_operation != 2'b00) begin
                    accept     = 1'b1;
                    cnt_next   = 4'(LAT);
                    state_next = S_BUSY;
                end else if (host_req) begin
                    host_go = 1'b1;
                end
            end
            S_BUSY: begin
                if (cnt == 4'd0) begin
                    complete   = 1'b1;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Engine and host writes never coincide: host only in IDLE, engine only in BUSY.
    always_comb begin
        mem_we    = (complete && is_wr && in_range) || (host_go && host_we);
        mem_waddr = complete ? idx : host_addr;
        mem_wdata = complete ? wdata_q : host_wdata;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_opdone <= 1'b0;
            rdata_o    <= '0;
            err_o      <= 1'b0;
            host_ack   <= 1'b0;
            host_rdata <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            mem_opdone <= complete;
            host_ack   <= host_go;
            if (accept) begin
                op_q    <= mem_operation;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            if (complete && is_rd) begin
                rdata_o <= in_range ? mem[idx] : '0;
            end
            if (host_go && !host_we) begin
                host_rdata <= mem[host_addr];
            end
            // A new error outranks a simultaneous clear.
            if (complete && (!in_range || is_ill)) begin
                err_o <= 1'b1;
            end else if (err_clr) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Randomized self-checking bench: two responders (LAT=0 and LAT=1) against an array-based model.
module tb_matrix_mem_responder;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn  [2];
    logic [1:0]    mop   [2];
    logic [31:0]   maddr [2];
    logic [DW-1:0] mwd   [2];
    logic [DW-1:0] rd    [2];
    logic          opdone[2];
    logic          err   [2];
    logic          eclr  [2];
    logic          hreq  [2];
    logic          hwe   [2];
    logic [AW-1:0] haddr [2];
    logic [DW-1:0] hwd   [2];
    logic [DW-1:0] hrd   [2];
    logic          hack  [2];

    int unsigned lat[2] = '{0, 1};

    logic [31:0] mm [2][DEPTH];
    logic [31:0] exp_rd [2];
    logic        exp_err[2];

    int n_checks = 0;
    int n_errs   = 0;

    matrix_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .LAT(0)) u_dut0 (
        .clk(clk), .reset_n(rstn[0]), .mem_operation(mop[0]), .addr_i(maddr[0]),
        .wdata_i(mwd[0]), .rdata_o(rd[0]), .mem_opdone(opdone[0]), .err_o(err[0]),
        .err_clr(eclr[0]), .host_req(hreq[0]), .host_we(hwe[0]), .host_addr(haddr[0]),
        .host_wdata(hwd[0]), .host_rdata(hrd[0]), .host_ack(hack[0])
    );

    matrix_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .LAT(1)) u_dut1 (
        .clk(clk), .reset_n(rstn[1]), .mem_operation(mop[1]), .addr_i(maddr[1]),
        .wdata_i(mwd[1]), .rdata_o(rd[1]), .mem_opdone(opdone[1]), .err_o(err[1]),
        .err_clr(eclr[1]), .host_req(hreq[1]), .host_we(hwe[1]), .host_addr(haddr[1]),
        .host_wdata(hwd[1]), .host_rdata(hrd[1]), .host_ack(hack[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_op(input int d, input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] w, input bit clr);
        bit oob;
        oob = (a >= DEPTH);
        if (clr) exp_err[d] = 1'b0;
        case (o)
            2'b01: begin
                exp_rd[d] = oob ? 32'd0 : mm[d][a[AW-1:0]];
                if (oob) exp_err[d] = 1'b1;
            end
            2'b11: begin
                if (oob) exp_err[d] = 1'b1;
                else     mm[d][a[AW-1:0]] = w;
            end
            default: exp_err[d] = 1'b1;
        endcase
    endfunction

    task automatic host_acc(input int d, input logic we, input int unsigned a, input logic [31:0] w);
        int n;
        bit seen;
        @(negedge clk);
        hreq[d] = 1'b1; hwe[d] = we; haddr[d] = a[AW-1:0]; hwd[d] = w;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1; n++;
            if (hack[d]) seen = 1'b1;
        end
        hreq[d] = 1'b0;
        chk("host_ack_seen", 32'(seen), 32'd1);
        chk("host_ack_lat", 32'(n), 32'd1);
        if (we) mm[d][a[AW-1:0]] = w;
        else    chk("host_rdata", hrd[d], mm[d][a[AW-1:0]]);
    endtask

    task automatic eng(input int d, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] w, input bit clr);
        int n;
        bit seen;
        @(negedge clk);
        mop[d] = o; maddr[d] = a; mwd[d] = w; eclr[d] = clr;
        @(posedge clk); #1;
        // request is latched; scramble inputs to show they are ignored
        mop[d] = 2'b00; maddr[d] = $urandom; mwd[d] = $urandom;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1; n++;
            if (opdone[d]) seen = 1'b1;
        end
        eclr[d] = 1'b0;
        model_op(d, o, a, w, clr);
        chk("opdone_seen", 32'(seen), 32'd1);
        chk("opdone_lat", 32'(n), lat[d] + 1);
        chk("rdata", rd[d], exp_rd[d]);
        chk("err", 32'(err[d]), 32'(exp_err[d]));
        @(posedge clk); #1;
        chk("opdone_single", 32'(opdone[d]), 32'd0);
    endtask

    task automatic fetch(input int d, input int unsigned cnt);
        int n;
        int unsigned k;
        @(negedge clk);
        mop[d] = 2'b01; maddr[d] = 32'd0;
        k = 0; n = 0;
        while (k < cnt && n < 40) begin
            @(posedge clk); #1; n++;
            if (opdone[d]) begin
                chk("fetch_gap", 32'(n), (k == 0) ? lat[d] + 2 : lat[d] + 3);
                chk("fetch_data", rd[d], mm[d][k[AW-1:0]]);
                k++; n = 0;
                if (k < cnt) maddr[d] = k;
                else         mop[d] = 2'b00;
            end
        end
        mop[d] = 2'b00;
        chk("fetch_count", k, cnt);
        exp_rd[d] = mm[d][AW'(cnt - 1)];
        @(posedge clk); #1;
        chk("fetch_tail_low", 32'(opdone[d]), 32'd0);
    endtask

    task automatic concur(input int d, input int unsigned ea, input int unsigned ha);
        int n, t_op, t_ack;
        @(negedge clk);
        mop[d] = 2'b01; maddr[d] = ea;
        hreq[d] = 1'b1; hwe[d] = 1'b0; haddr[d] = ha[AW-1:0];
        t_op = -1; t_ack = -1; n = 0;
        while (t_ack < 0 && n < 40) begin
            @(posedge clk); #1; n++;
            if (n == 1) mop[d] = 2'b00;
            if (opdone[d]) t_op = n;
            if (hack[d]) begin
                t_ack = n;
                hreq[d] = 1'b0;
            end
        end
        hreq[d] = 1'b0;
        exp_rd[d] = mm[d][ea[AW-1:0]];
        chk("conc_opdone_t", 32'(t_op), lat[d] + 2);
        chk("conc_ack_t", 32'(t_ack), lat[d] + 4);
        chk("conc_rdata", rd[d], exp_rd[d]);
        chk("conc_hrdata", hrd[d], mm[d][ha[AW-1:0]]);
    endtask

    task automatic clr_err(input int d);
        @(negedge clk); eclr[d] = 1'b1;
        @(posedge clk); #1; eclr[d] = 1'b0;
        exp_err[d] = 1'b0;
        chk("err_clr", 32'(err[d]), 32'd0);
    endtask

    task automatic chk_reset_outs(input int d);
        chk("rst_opdone", 32'(opdone[d]), 32'd0);
        chk("rst_rdata", rd[d], 32'd0);
        chk("rst_err", 32'(err[d]), 32'd0);
        chk("rst_hack", 32'(hack[d]), 32'd0);
        chk("rst_hrdata", hrd[d], 32'd0);
    endtask

    initial begin
        int d;
        int unsigned r, a;
        bit seen;
        for (int i = 0; i < 2; i++) begin
            rstn[i] = 1'b0; mop[i] = 2'b00; maddr[i] = '0; mwd[i] = '0; eclr[i] = 1'b0;
            hreq[i] = 1'b0; hwe[i] = 1'b0; haddr[i] = '0; hwd[i] = '0;
            exp_rd[i] = '0; exp_err[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs(0);
        chk_reset_outs(1);
        @(negedge clk);
        rstn[0] = 1'b1; rstn[1] = 1'b1;

        for (int i = 0; i < 2; i++)
            for (int unsigned j = 0; j < 64; j++)
                host_acc(i, 1'b1, j, (j < 4) ? 32'd2 : $urandom);

        eng(1, 2'b01, 32'd0, 32'd0, 1'b0);
        eng(0, 2'b11, 32'd20, 32'h1234, 1'b0);
        eng(0, 2'b01, 32'd20, 32'd0, 1'b0);
        fetch(1, 5);
        fetch(0, 5);

        eng(1, 2'b01, 32'h0000_0400, 32'd0, 1'b0);
        clr_err(1);
        eng(1, 2'b10, 32'd5, 32'hFFFF_FFFF, 1'b0);
        host_acc(1, 1'b0, 5, 32'd0);
        eng(1, 2'b11, 32'h8000_0005, 32'hBAD0_BAD0, 1'b0);
        host_acc(1, 1'b0, 5, 32'd0);
        eng(1, 2'b01, 32'h0001_0000, 32'd0, 1'b1);

        concur(1, 3, 10);
        concur(0, 12, 40);

        for (int i = 0; i < 60; i++) begin
            d = int'($urandom % 2);
            r = $urandom % 10;
            a = $urandom % 64;
            if (r < 4)       eng(d, 2'b01, a, 32'd0, ($urandom % 5) == 0);
            else if (r < 7)  eng(d, 2'b11, a, $urandom, ($urandom % 5) == 0);
            else if (r == 7) eng(d, ($urandom % 2) ? 2'b01 : 2'b11, $urandom | 32'h0000_0400,
                                 $urandom, ($urandom % 5) == 0);
            else if (r == 8) eng(d, 2'b10, a, $urandom, 1'b0);
            else             host_acc(d, 1'(($urandom % 2)), a, $urandom);
        end

        host_acc(1, 1'b1, 7, 32'hCAFE_0007);
        eng(1, 2'b01, 32'd7, 32'd0, 1'b0);
        eng(1, 2'b10, 32'd7, 32'd0, 1'b0);
        host_acc(1, 1'b0, 7, 32'd0);
        @(negedge clk);
        mop[1] = 2'b11; maddr[1] = 32'd7; mwd[1] = 32'h0000_DEAD;
        @(posedge clk); #1;
        mop[1] = 2'b00;
        rstn[1] = 1'b0;
        #1;
        chk_reset_outs(1);
        exp_rd[1] = '0; exp_err[1] = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (opdone[1]) seen = 1'b1;
        end
        @(negedge clk); rstn[1] = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (opdone[1]) seen = 1'b1;
        end
        chk("rst_no_opdone", 32'(seen), 32'd0);
        host_acc(1, 1'b0, 7, 32'd0);
        eng(1, 2'b01, 32'd7, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
